main_memory_responder: RTL and testbench

Word-addressed backing store that answers the data cache on its memory side. Serves 4-word block fills for read misses and commits single-word write-through stores, each after a fixed programmable latency. Sits between the cache/processor memory-stage controller and nothing further; it is the last level of the data hierarchy.

---
 rtl/main_memory_responder_if.sv | 32 +++
 rtl/main_memory_responder.sv | 128 ++++++++++++
 tb/tb_main_memory_responder.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/main_memory_responder_if.sv
// Memory-side bus between the data cache controller and the main memory responder.
// Latency: none (wires only).
// Backpressure: the requester holds MemRead/MemWrite while Busy is high; requests are not queued.
//
// Signals:
//   MemRead/MemWrite  block-fill / write-through request (cache -> memory)
//   WordAddress       word address of the request
//   WriteData         store data for MemWrite
//   BlockOut          4-word fill block, word k in bits [32k+31:32k]
//   fill              one-cycle strobe, BlockOut valid
//   Busy              access in progress
interface main_memory_responder_if #(
    parameter int ADDR_W = 10
);
    logic              MemRead;
    logic              MemWrite;
    logic [ADDR_W-1:0] WordAddress;
    logic [31:0]       WriteData;
    logic [127:0]      BlockOut;
    logic              fill;
    logic              Busy;

    modport master (
        output MemRead, MemWrite, WordAddress, WriteData,
        input  BlockOut, fill, Busy
    );

    modport slave (
        input  MemRead, MemWrite, WordAddress, WriteData,
        output BlockOut, fill, Busy
    );
endinterface

// File: rtl/main_memory_responder.sv
// Word-addressed backing store: 4-word block fills for reads, single-word write-through stores.
// Latency: LAT cycles from accept to fill strobe / memory commit; one access in flight.
// Backpressure: Busy high while an access is pending; requests seen outside IDLE are dropped.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  synchronous active-low reset; aborts any pending access and clears the store
//   bus    slave side of main_memory_responder_if (requests in, BlockOut/fill/Busy out)
module main_memory_responder #(
    parameter int ADDR_W = 10,
    parameter int LAT    = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    main_memory_responder_if.slave   bus
);

    localparam int         DEPTH  = 2 ** ADDR_W;
    localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] addr_lat;
    logic [31:0]       data_lat;
    logic [127:0]      block_reg;
    logic              fill_reg;
    logic              busy;
    logic [31:0]       mem [DEPTH];

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a write wins over a simultaneous read
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.MemWrite) begin
                    state_nxt = WR_WAIT;
                end else if (bus.MemRead) begin
                    state_nxt = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = IDLE;
                end
            end
            WR_WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs derived from registered state only
    always_comb begin
        busy = (state != IDLE);
    end

    // Datapath: counter, request latches, storage and fill block
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= 4'd0;
            addr_lat  <= '0;
            data_lat  <= 32'd0;
            fill_reg  <= 1'b0;
            block_reg <= 128'd0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 32'd0;
            end
        end else begin
            fill_reg <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.MemWrite) begin
                        addr_lat <= bus.WordAddress;
                        data_lat <= bus.WriteData;
                        cnt      <= LAT_M1;
                    end else if (bus.MemRead) begin
                        // Reads always fetch the aligned block; low two bits are dropped
                        addr_lat <= {bus.WordAddress[ADDR_W-1:2], 2'b00};
                        cnt      <= LAT_M1;
                    end
                end
                RD_WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        block_reg <= {mem[{addr_lat[ADDR_W-1:2], 2'd3}],
                                      mem[{addr_lat[ADDR_W-1:2], 2'd2}],
                                      mem[{addr_lat[ADDR_W-1:2], 2'd1}],
                                      mem[{addr_lat[ADDR_W-1:2], 2'd0}]};
                        fill_reg  <= 1'b1;
                    end
                end
                WR_WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        mem[addr_lat] <= data_lat;
                    end
                end
                default: cnt <= 4'd0;
            endcase
        end
    end

    assign bus.BlockOut = block_reg;
    assign bus.fill     = fill_reg;
    assign bus.Busy     = busy;

endmodule

// File: tb/tb_main_memory_responder.sv
// Bench for main_memory_responder: instance A with LAT=4, instance B with LAT=1.
// Drivers push expected fills (block + cycle) into per-instance queues; monitors pop on each fill.
module tb_main_memory_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;
    int   ecount = 0;
    int   n_cmp  = 0;
    int   n_bad  = 0;

    always @(posedge clk) ecount++;

    typedef struct {
        logic [127:0] blk;
        int           cyc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    main_memory_responder_if #(.ADDR_W(10)) a_if ();
    main_memory_responder_if #(.ADDR_W(10)) b_if ();

    main_memory_responder #(.ADDR_W(10), .LAT(4)) dut_a (
        .clk   (clk),
        .rst_n (rst_a),
        .bus   (a_if.slave)
    );

    main_memory_responder #(.ADDR_W(10), .LAT(1)) dut_b (
        .clk   (clk),
        .rst_n (rst_b),
        .bus   (b_if.slave)
    );

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic rd, input logic wr,
                         input logic [9:0] ad, input logic [31:0] d);
        if (sel) begin
            b_if.MemRead = rd; b_if.MemWrite = wr; b_if.WordAddress = ad; b_if.WriteData = d;
        end else begin
            a_if.MemRead = rd; a_if.MemWrite = wr; a_if.WordAddress = ad; a_if.WriteData = d;
        end
    endtask

    function automatic logic busy_of(input bit sel);
        return sel ? b_if.Busy : a_if.Busy;
    endfunction

    // Present a request for one accept edge; push the expected fill for a pure read
    task automatic issue(input bit sel, input logic rd, input logic wr, input logic [9:0] ad,
                         input logic [31:0] d, input logic [127:0] exp, output int acc);
        exp_t e;
        @(negedge clk);
        drive(sel, rd, wr, ad, d);
        @(posedge clk);
        #1;
        acc = ecount;
        drive(sel, 1'b0, 1'b0, 10'd0, 32'd0);
        if (rd && !wr) begin
            e.blk = exp;
            e.cyc = acc + (sel ? 1 : 4);
            if (sel) qb.push_back(e); else qa.push_back(e);
        end
    endtask

    // Count remaining Busy cycles, bounded
    task automatic run_busy(input bit sel, input string nm, output int n);
        bit done;
        n    = 0;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (busy_of(sel) === 1'b1) n++;
            else done = 1'b1;
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s timeout: Busy still high after 40 cycles", nm);
        end
    endtask

    task automatic access(input bit sel, input logic rd, input logic wr, input logic [9:0] ad,
                          input logic [31:0] d, input logic [127:0] exp, input string nm,
                          input int exp_busy);
        int acc;
        int n;
        issue(sel, rd, wr, ad, d, exp, acc);
        run_busy(sel, nm, n);
        check({nm, " busy cycles"}, 128'(n), 128'(exp_busy));
    endtask

    always @(negedge clk) begin
        if (a_if.fill === 1'b1) begin
            if (qa.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL a unexpected fill: got fill=1 block %h expected no fill", a_if.BlockOut);
            end else begin
                exp_t e;
                e = qa.pop_front();
                check("a fill block", a_if.BlockOut, e.blk);
                check("a fill cycle", 128'(ecount), 128'(e.cyc));
            end
        end
    end

    always @(negedge clk) begin
        if (b_if.fill === 1'b1) begin
            if (qb.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL b unexpected fill: got fill=1 block %h expected no fill", b_if.BlockOut);
            end else begin
                exp_t e;
                e = qb.pop_front();
                check("b fill block", b_if.BlockOut, e.blk);
                check("b fill cycle", 128'(ecount), 128'(e.cyc));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int n;
        rst_a = 1'b0;
        rst_b = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 10'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 10'd0, 32'd0);
        repeat (3) @(negedge clk);
        check("a reset Busy", 128'(a_if.Busy), 128'd0);
        check("a reset fill", 128'(a_if.fill), 128'd0);
        check("a reset BlockOut", a_if.BlockOut, 128'd0);
        check("b reset Busy", 128'(b_if.Busy), 128'd0);
        check("b reset BlockOut", b_if.BlockOut, 128'd0);
        rst_a = 1'b1;
        rst_b = 1'b1;

        // Read after reset: all zero, 4 busy cycles, fill 4 cycles after accept
        access(1'b0, 1'b1, 1'b0, 10'h005, 32'd0, 128'd0, "a read 005", 4);

        // Write-through then read of the containing block
        access(1'b0, 1'b0, 1'b1, 10'h106, 32'hDEADBEEF, 128'd0, "a write 106", 4);
        access(1'b0, 1'b1, 1'b0, 10'h104, 32'd0, {32'h0, 32'hDEADBEEF, 64'h0}, "a read 104", 4);

        // Simultaneous read+write: write wins, no fill; reissued read sees it
        access(1'b0, 1'b1, 1'b1, 10'h010, 32'hCAFEF00D, 128'd0, "a rdwr 010", 4);
        access(1'b0, 1'b1, 1'b0, 10'h010, 32'd0, {96'h0, 32'hCAFEF00D}, "a read 010", 4);

        // Requests toggled during RD_WAIT are dropped; BlockOut stable until the fill
        issue(1'b0, 1'b1, 1'b0, 10'h104, 32'd0, {32'h0, 32'hDEADBEEF, 64'h0}, acc);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("a BlockOut hold", a_if.BlockOut, {96'h0, 32'hCAFEF00D});
            drive(1'b0, k[0] ? 1'b0 : 1'b1, 1'b1, 10'h200, 32'h00000055);
        end
        @(negedge clk);
        check("a BlockOut hold last", a_if.BlockOut, {96'h0, 32'hCAFEF00D});
        drive(1'b0, 1'b0, 1'b0, 10'd0, 32'd0);
        run_busy(1'b0, "a toggled read", n);
        access(1'b0, 1'b1, 1'b0, 10'h200, 32'd0, 128'd0, "a read 200", 4);

        // Reset during a write: aborted, nothing committed, no fill
        issue(1'b0, 1'b0, 1'b1, 10'h3FF, 32'h12345678, 128'd0, acc);
        @(negedge clk);
        @(negedge clk);
        rst_a = 1'b0;
        @(negedge clk);
        rst_a = 1'b1;
        check("a mid-reset Busy", 128'(a_if.Busy), 128'd0);
        check("a mid-reset BlockOut", a_if.BlockOut, 128'd0);
        access(1'b0, 1'b1, 1'b0, 10'h3FC, 32'd0, 128'd0, "a read 3FC", 4);

        // LAT=1 instance: preload words 1..8, then back-to-back reads
        for (int w = 0; w < 8; w++) begin
            access(1'b1, 1'b0, 1'b1, 10'(w), 32'(w + 1), 128'd0, "b preload", 1);
        end
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 10'h000, 32'd0);
        @(posedge clk);
        #1;
        acc = ecount;
        qb.push_back('{blk: {32'd4, 32'd3, 32'd2, 32'd1}, cyc: acc + 1});
        qb.push_back('{blk: {32'd8, 32'd7, 32'd6, 32'd5}, cyc: acc + 3});
        drive(1'b1, 1'b1, 1'b0, 10'h004, 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("b idle in fill cycle", 128'(b_if.Busy), 128'd0);
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 1'b0, 10'd0, 32'd0);
        run_busy(1'b1, "b second read", n);
        check("b second read busy cycles", 128'(n), 128'd1);

        repeat (4) @(negedge clk);
        check("a pending fills", 128'(qa.size()), 128'd0);
        check("b pending fills", 128'(qb.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
